// File: rtl/mul_pkg.sv
// Shared constants, FSM state encoding and helpers for the multiplier arbiter.
package mul_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned OP_W    = 32;
    localparam int unsigned PROD_W  = 64;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned WD_W    = 6;
    localparam logic [WD_W-1:0] TIMEOUT = 6'd47;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = 2'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (oh[k]) begin
                idx = 2'(k);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mul_arbiter_rr_select.sv
// Rotating-priority selector: first requester above last_grant, wrapping around.
module rr_select
    import mul_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               any_o
);

    logic             found_s;
    logic [IDX_W-1:0] idx_s;

    // Scan upward from last_grant+1; the 2-bit index wraps naturally.
    always_comb begin
        grant_o = 4'b0000;
        found_s = 1'b0;
        idx_s   = 2'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_s = last_grant_i + 2'(k);
            if (!found_s && req_i[idx_s]) begin
                grant_o[idx_s] = 1'b1;
                found_s        = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/mul_arbiter.sv
// Arbitrates four requesters onto one shared multiplier, one transaction at a time,
// with a watchdog that turns a hung multiplication into an error response.
module mul_arbiter
    import mul_pkg::*;
(
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*OP_W-1:0]   req_a,
    input  logic [NUM_REQ*OP_W-1:0]   req_b,
    output logic [NUM_REQ-1:0]        req_accept,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [PROD_W-1:0]         rsp_product,
    output logic                      rsp_err,
    input  logic [NUM_REQ-1:0]        rsp_ack,
    output logic                      mul_valid,
    output logic [OP_W-1:0]           mul_a,
    output logic [OP_W-1:0]           mul_b,
    input  logic                      mul_done,
    input  logic [PROD_W-1:0]         mul_product,
    output logic                      mul_ack,
    output logic                      err_timeout
);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [NUM_REQ-1:0]  req_accept_q, req_accept_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [PROD_W-1:0]   rsp_product_q, rsp_product_d;
    logic                rsp_err_q, rsp_err_d;
    logic                mul_valid_q, mul_valid_d;
    logic [OP_W-1:0]     mul_a_q, mul_a_d;
    logic [OP_W-1:0]     mul_b_q, mul_b_d;
    logic                mul_ack_q, mul_ack_d;
    logic                err_timeout_q, err_timeout_d;

    logic [NUM_REQ-1:0]  grant_s;
    logic                any_s;
    logic [IDX_W-1:0]    grant_idx_s;

    rr_select u_rr_select (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant_s),
        .any_o        (any_s)
    );

    assign grant_idx_s = onehot_to_idx(grant_s);

    // Next-state and next-output logic; pulses default low every cycle.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        wd_d          = wd_q;
        req_accept_d  = 4'b0000;
        rsp_valid_d   = rsp_valid_q;
        rsp_product_d = rsp_product_q;
        rsp_err_d     = rsp_err_q;
        mul_valid_d   = 1'b0;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        mul_ack_d     = 1'b0;
        err_timeout_d = err_timeout_q;
        case (state_q)
            IDLE: begin
                if (any_s) begin
                    grant_d      = grant_s;
                    req_accept_d = grant_s;
                    mul_a_d      = req_a[32'(grant_idx_s) * OP_W +: OP_W];
                    mul_b_d      = req_b[32'(grant_idx_s) * OP_W +: OP_W];
                    mul_valid_d  = 1'b1;
                    state_d      = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                wd_d    = 6'd0;
                state_d = WAIT;
            end
            WAIT: begin
                if (mul_done) begin
                    rsp_product_d = mul_product;
                    rsp_err_d     = 1'b0;
                    rsp_valid_d   = grant_q;
                    mul_ack_d     = 1'b1;
                    state_d       = RESP;
                end else if (wd_q == TIMEOUT) begin
                    rsp_product_d = 64'd0;
                    rsp_err_d     = 1'b1;
                    rsp_valid_d   = grant_q;
                    err_timeout_d = 1'b1;
                    mul_ack_d     = 1'b1;
                    state_d       = RESP;
                end else begin
                    wd_d = wd_q + 6'd1;
                end
            end
            RESP: begin
                // Only the granted requester's ack bit releases the response.
                if (|(rsp_ack & grant_q)) begin
                    last_grant_d  = onehot_to_idx(grant_q);
                    rsp_valid_d   = 4'b0000;
                    rsp_product_d = 64'd0;
                    rsp_err_d     = 1'b0;
                    state_d       = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= IDLE;
            last_grant_q  <= 2'd3;
            grant_q       <= 4'b0000;
            wd_q          <= 6'd0;
            req_accept_q  <= 4'b0000;
            rsp_valid_q   <= 4'b0000;
            rsp_product_q <= 64'd0;
            rsp_err_q     <= 1'b0;
            mul_valid_q   <= 1'b0;
            mul_a_q       <= 32'd0;
            mul_b_q       <= 32'd0;
            mul_ack_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            wd_q          <= wd_d;
            req_accept_q  <= req_accept_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_product_q <= rsp_product_d;
            rsp_err_q     <= rsp_err_d;
            mul_valid_q   <= mul_valid_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            mul_ack_q     <= mul_ack_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign req_accept  = req_accept_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_product = rsp_product_q;
    assign rsp_err     = rsp_err_q;
    assign mul_valid   = mul_valid_q;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign mul_ack     = mul_ack_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter: directed requests push expected accepts and
// responses; a monitor pops and compares whenever the DUT presents them.
module tb_mul_arbiter;

    logic          Clock;
    logic          Reset;
    logic [3:0]    req_valid;
    logic [127:0]  req_a;
    logic [127:0]  req_b;
    logic [3:0]    req_accept;
    logic [3:0]    rsp_valid;
    logic [63:0]   rsp_product;
    logic          rsp_err;
    logic [3:0]    rsp_ack;
    logic          mul_valid;
    logic [31:0]   mul_a;
    logic [31:0]   mul_b;
    logic          mul_done;
    logic [63:0]   mul_product;
    logic          mul_ack;
    logic          err_timeout;

    mul_arbiter dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_accept  (req_accept),
        .rsp_valid   (rsp_valid),
        .rsp_product (rsp_product),
        .rsp_err     (rsp_err),
        .rsp_ack     (rsp_ack),
        .mul_valid   (mul_valid),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_done    (mul_done),
        .mul_product (mul_product),
        .mul_ack     (mul_ack),
        .err_timeout (err_timeout)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [3:0]  g;
        logic [31:0] a;
        logic [31:0] b;
    } acc_t;

    typedef struct {
        logic [3:0]  g;
        logic [63:0] prod;
        logic        err;
    } rsp_t;

    acc_t acc_q[$];
    rsp_t rsp_q[$];

    int checks = 0;
    int passes = 0;
    int mv_cnt = 0;
    int ack_cnt = 0;
    int model_delay = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expire(input string name);
        checks++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Expected accept and response for a request from requester idx.
    task automatic issue(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] prod, input logic err, input bit has_rsp);
        acc_t e;
        rsp_t r;
        e.g = 4'(1 << idx);
        e.a = a;
        e.b = b;
        acc_q.push_back(e);
        if (has_rsp) begin
            r.g    = 4'(1 << idx);
            r.prod = prod;
            r.err  = err;
            rsp_q.push_back(r);
        end
        req_a[idx*32 +: 32] = a;
        req_b[idx*32 +: 32] = b;
    endtask

    // Multiplier model: raises done model_delay cycles after mul_valid; never if negative.
    logic [31:0] ma, mb;
    int          mcnt;
    bit          busy;
    always @(negedge Clock) begin
        if (Reset) begin
            busy        = 1'b0;
            mul_done    = 1'b0;
            mul_product = 64'd0;
        end else if (mul_ack) begin
            busy     = 1'b0;
            mul_done = 1'b0;
        end else if (mul_valid) begin
            busy = 1'b1;
            mcnt = model_delay;
            ma   = mul_a;
            mb   = mul_b;
        end else if (busy && !mul_done && mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin
                mul_done    = 1'b1;
                mul_product = {32'd0, ma} * {32'd0, mb};
            end
        end
    end

    // Monitor: pops the scoreboard whenever an accept or a new response appears.
    logic [3:0] prev_rsp = 4'b0000;
    always @(negedge Clock) begin
        acc_t e;
        rsp_t r;
        if (!Reset) begin
            if (req_accept != 4'b0000) begin
                if (acc_q.size() == 0) begin
                    expire("unexpected_accept");
                end else begin
                    e = acc_q.pop_front();
                    check("req_accept", {60'd0, req_accept}, {60'd0, e.g});
                    check("mul_valid_with_accept", {63'd0, mul_valid}, 64'd1);
                    check("mul_a", {32'd0, mul_a}, {32'd0, e.a});
                    check("mul_b", {32'd0, mul_b}, {32'd0, e.b});
                end
            end
            if (mul_valid) mv_cnt++;
            if (mul_ack) ack_cnt++;
            if (rsp_valid != 4'b0000 && prev_rsp == 4'b0000) begin
                if (rsp_q.size() == 0) begin
                    expire("unexpected_rsp");
                end else begin
                    r = rsp_q.pop_front();
                    check("rsp_valid", {60'd0, rsp_valid}, {60'd0, r.g});
                    check("rsp_product", rsp_product, r.prod);
                    check("rsp_err", {63'd0, rsp_err}, {63'd0, r.err});
                    check("mul_ack_with_rsp", {63'd0, mul_ack}, 64'd1);
                end
            end
        end
        prev_rsp = rsp_valid;
    end

    task automatic wait_accept(input string name);
        int n;
        for (n = 0; n < 100; n++) begin
            @(negedge Clock);
            if (req_accept != 4'b0000) break;
        end
        if (n == 100) expire(name);
    endtask

    // Wait for a response, hold it for `hold` cycles checking it stays, then ack it.
    task automatic serve_one(input logic [3:0] exp_g, input int hold, input bit drop);
        int n;
        for (n = 0; n < 300; n++) begin
            if (rsp_valid != 4'b0000) break;
            @(negedge Clock);
        end
        if (n == 300) expire("rsp_wait");
        for (int h = 0; h < hold; h++) begin
            @(negedge Clock);
            check("rsp_hold", {60'd0, rsp_valid}, {60'd0, exp_g});
        end
        rsp_ack = exp_g;
        @(negedge Clock);
        rsp_ack = 4'b0000;
        if (drop) req_valid = 4'b0000;
        check("rsp_clear", {60'd0, rsp_valid}, 64'd0);
    endtask

    int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    logic [31:0] ra [4] = '{32'd3, 32'd10, 32'd1000, 32'h0001_0000};
    logic [31:0] rb [4] = '{32'd5, 32'd11, 32'd1000, 32'h0001_0000};
    logic [63:0] rp [4] = '{64'd15, 64'd110, 64'd1000000, 64'h0000_0001_0000_0000};

    initial begin
        int gap;
        Reset     = 1'b1;
        req_valid = 4'b0000;
        req_a     = 128'd0;
        req_b     = 128'd0;
        rsp_ack   = 4'b0000;
        repeat (3) @(negedge Clock);
        check("reset_ctl", {58'd0, req_accept, rsp_valid, rsp_err, mul_valid, mul_ack, err_timeout}, 64'd0);
        check("reset_product", rsp_product, 64'd0);
        check("reset_ops", {mul_a, mul_b}, 64'd0);
        Reset = 1'b0;

        // Single request, 7*6 with a 34-cycle multiplier.
        model_delay = 34;
        issue(0, 32'd7, 32'd6, 64'd42, 1'b0, 1'b1);
        req_valid = 4'b0001;
        wait_accept("acc_basic");
        req_valid = 4'b0000;
        serve_one(4'b0001, 3, 1'b0);

        // Largest operands.
        model_delay = 4;
        issue(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b1);
        req_valid = 4'b1000;
        wait_accept("acc_max");
        req_valid = 4'b0000;
        serve_one(4'b1000, 0, 1'b0);

        // Four requesters held: round-robin over eight transactions.
        model_delay = 2;
        for (int k = 0; k < 8; k++) begin
            issue(order[k], ra[order[k]], rb[order[k]], rp[order[k]], 1'b0, 1'b1);
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            serve_one(4'(1 << order[k]), 0, k == 7);
        end

        // Multiplier hangs: watchdog produces an error response.
        model_delay = -1;
        issue(1, 32'd5, 32'd9, 64'd0, 1'b1, 1'b1);
        req_valid = 4'b0010;
        wait_accept("acc_timeout");
        req_valid = 4'b0000;
        gap = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge Clock);
            if (mul_ack) begin
                gap = n;
                break;
            end
        end
        check("timeout_gap", 64'(gap), 64'd49);
        serve_one(4'b0010, 1, 1'b0);
        check("err_timeout_set", {63'd0, err_timeout}, 64'd1);

        model_delay = 5;
        issue(2, 32'd4, 32'd4, 64'd16, 1'b0, 1'b1);
        req_valid = 4'b0100;
        wait_accept("acc_after_timeout");
        req_valid = 4'b0000;
        serve_one(4'b0100, 0, 1'b0);
        check("err_timeout_sticky", {63'd0, err_timeout}, 64'd1);

        // Foreign ack bits must not release requester 1's response.
        model_delay = 3;
        issue(1, 32'd2, 32'd3, 64'd6, 1'b0, 1'b1);
        req_valid = 4'b0010;
        wait_accept("acc_foreign_ack");
        req_valid = 4'b0000;
        for (int n = 0; n < 100; n++) begin
            if (rsp_valid != 4'b0000) break;
            @(negedge Clock);
        end
        rsp_ack = 4'b1100;
        for (int h = 0; h < 5; h++) begin
            @(negedge Clock);
            check("foreign_ack_hold", {60'd0, rsp_valid}, 64'd2);
        end
        rsp_ack = 4'b0010;
        @(negedge Clock);
        rsp_ack = 4'b0000;
        check("own_ack_clear", {60'd0, rsp_valid}, 64'd0);

        // Reset during WAIT abandons the transaction and restores priority.
        model_delay = -1;
        issue(0, 32'd1, 32'd1, 64'd1, 1'b0, 1'b0);
        req_valid = 4'b0001;
        wait_accept("acc_abort");
        req_valid = 4'b0000;
        repeat (5) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        check("midrst_ctl", {58'd0, req_accept, rsp_valid, rsp_err, mul_valid, mul_ack, err_timeout}, 64'd0);
        check("midrst_product", rsp_product, 64'd0);
        check("midrst_ops", {mul_a, mul_b}, 64'd0);
        Reset = 1'b0;
        model_delay = 3;
        issue(2, 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780, 1'b0, 1'b1);
        req_valid = 4'b0100;
        wait_accept("acc_post_reset");
        req_valid = 4'b0000;
        serve_one(4'b0100, 0, 1'b0);

        repeat (3) @(negedge Clock);
        check("acc_queue_empty", 64'(acc_q.size()), 64'd0);
        check("rsp_queue_empty", 64'(rsp_q.size()), 64'd0);
        check("mul_valid_pulses", 64'(mv_cnt), 64'd15);
        check("mul_ack_pulses", 64'(ack_cnt), 64'd14);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 The block SHALL have these ports (clock and reset first):
  Clock  in  1  single clock; all state updates on rising edge
  Reset  in  1  synchronous, active-high reset
  req_valid  in  4  requester i has operands ready (level)
  req_a  in  128  operand A, requester i at bits [32i+31:32i]
  req_b  in  128  operand B, same packing
  req_accept  out  4  one-hot, one-cycle pulse: operands of requester i latched
  rsp_valid  out  4  one-hot: result for requester i is presented
  rsp_product  out  64  result of the granted request
  rsp_err  out  1  presented result is invalid (timeout); qualified by rsp_valid
  rsp_ack  in  4  requester i consumed its result
  mul_valid  out  1  start pulse to the shift-add multiplier controller
  mul_a  out  32  operand A to the multiplier
  mul_b  out  32  operand B to the multiplier
  mul_done  in  1  multiplier result ready (level, held until mul_ack)
  mul_product  in  64  multiplier result
  mul_ack  out  1  one-cycle pulse releasing the multiplier to its idle state
  err_timeout  out  1  sticky: a multiplication exceeded the timeout
REQ-002 Reset SHALL be synchronous and active-high on port Reset; there SHALL be a single clock, Clock.

Function
REQ-003 All outputs SHALL be registered.
REQ-004 States SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-005 IDLE: when any req_valid bit is 1, grant g = first set bit searching upward, with wrap, from last_grant+1; latch req_a/req_b slice g into mul_a/mul_b; pulse req_accept[g]; go to ISSUE. No request: stay.
REQ-006 ISSUE: mul_valid SHALL be 1 for exactly this one cycle, with mul_a/mul_b stable; then go to WAIT with watchdog = 0.
REQ-007 WAIT: watchdog increments each cycle; on mul_done=1 capture mul_product, pulse mul_ack for one cycle, rsp_err = 0, go to RESP.
REQ-008 WAIT timeout: when watchdog reaches 47 with mul_done still 0, set err_timeout, load rsp_product = 0, set rsp_err = 1, pulse mul_ack, go to RESP.
REQ-009 RESP: hold rsp_valid[g], rsp_product and rsp_err until rsp_ack[g]=1; then set last_grant = g, clear rsp_valid, and go to IDLE. rsp_ack bits other than g SHALL be ignored.
REQ-010 mul_done SHALL be sampled only in WAIT; req_valid only in IDLE. A requester that drops req_valid before its grant loses nothing and is not accepted.
REQ-011 With four simultaneous requests, grants SHALL rotate so that each requester is served exactly once per four transactions.
REQ-012 A requester SHALL NOT be granted again while its own result is in RESP; only one transaction is outstanding at a time.
REQ-013 Latency: a request seen in IDLE at edge N gives req_accept and mul_valid at N+1, and WAIT at N+2; rsp_valid follows mul_done by one cycle.

Reset
REQ-014 Reset SHALL force state = IDLE, last_grant = 3 (requester 0 has first priority), watchdog = 0, and clear every output to 0, including err_timeout.
REQ-015 Reset asserted mid-transaction SHALL abandon it without a response; the integrator resets the multiplier on the same Reset.

Structure
REQ-016 State encodings, NUM_REQ = 4, OP_W = 32, PROD_W = 64 and TIMEOUT = 47 SHALL live in the shared package mul_pkg.
REQ-017 The rotating-priority grant selection SHALL be a combinational sub-module rr_select (inputs: req vector, last_grant; outputs: one-hot grant, any).

Verification
REQ-018 Reset release, req_valid = 0001, A = 7, B = 6, multiplier model returns done after 34 cycles -> req_accept = 0001 one cycle, one mul_valid pulse, rsp_valid = 0001 with rsp_product = 42 and rsp_err = 0 until rsp_ack.
REQ-019 req_valid = 1111 held, eight transactions -> grant order 0,1,2,3,0,1,2,3.
REQ-020 A = FFFFFFFF, B = FFFFFFFF -> rsp_product = FFFFFFFE00000001.
REQ-021 Multiplier model never asserts mul_done -> mul_ack pulse 48 cycles after WAIT entry, rsp_product = 0, rsp_err = 1, err_timeout = 1 remaining set after the next good transaction.
REQ-022 Reset pulsed during WAIT -> next cycle all outputs 0 and state IDLE; a following req_valid = 0100 is granted to requester 2.
REQ-023 In RESP for g = 1, rsp_ack = 1100 asserted for 5 cycles and then rsp_ack = 0010 -> rsp_valid = 0010 holds through the 5 cycles and clears only after rsp_ack = 0010.
